mul16_seq: RTL and testbench

Sequential unsigned WIDTH x WIDTH shift-and-add multiplier built around one WIDTH-bit add per clock.
It sits beside the 16-bit adder in the datapath and consumes the same operand buses.
It produces a 2*WIDTH-bit product and a 16-bit status word in the same style as the adder's status output.
Start/busy/done handshake; one operation in flight at a time.

---
 rtl/mul16_seq.sv | 101 ++++++++++
 tb/tb_mul16_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mul16_seq.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier, one WIDTH-bit add per clock.
// Start/busy/done handshake; product and status are registered and change only on completion.
module mul16_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [15:0]          status
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state, next_state;
    logic [WIDTH-1:0]   acc, mcand, mplier;
    logic [CW-1:0]      count;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   acc_nxt, mplier_nxt;
    logic [2*WIDTH-1:0] final_prod;
    logic [15:0]        status_nxt;
    logic               last;

    // One iteration: conditional add, then shift {carry, sum, mplier} right by one.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sum        = {1'b0, acc} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_nxt    = sum[WIDTH:1];
        mplier_nxt = {sum[0], mplier[WIDTH-1:1]};
        final_prod = {acc_nxt, mplier_nxt};
        status_nxt = '0;
        status_nxt[0] = (final_prod == '0);
        status_nxt[1] = |final_prod[2*WIDTH-1:WIDTH];
        status_nxt[2] = final_prod[2*WIDTH-1];
        last       = (count == CW'(WIDTH - 1));
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
            status  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= A;
                        mplier <= B;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mplier <= mplier_nxt;
                    count  <= count + CW'(1);
                    // Results are published only on the final iteration, never partially.
                    if (last) begin
                        product <= final_prod;
                        status  <= status_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq: directed scenarios plus randomized operands
// compared against plain-arithmetic expectations.
module tb_mul16_seq;

    localparam int WIDTH = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [15:0] A, B;
    logic        busy, done;
    logic [31:0] product;
    logic [15:0] status;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 CLK = ~CLK;

    mul16_seq #(.WIDTH(WIDTH)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .product (product),
        .status  (status)
    );

    function automatic logic [31:0] model_product(input logic [15:0] a, input logic [15:0] b);
        return {16'b0, a} * {16'b0, b};
    endfunction

    function automatic logic [15:0] model_status(input logic [31:0] p);
        logic [15:0] s;
        s    = 16'h0000;
        s[0] = (p == 32'h0);
        s[1] = (p[31:16] != 16'h0);
        s[2] = p[31];
        return s;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Bounded wait after an accepted start: counts done pulses and the first done index.
    task automatic wait_done(output int lat, output int pulses);
        lat    = -1;
        pulses = 0;
        for (int i = 1; i <= WIDTH + 4; i++) begin
            tick();
            if (done === 1'b1) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat, output int pulses);
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, pulses);
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
        total_cnt++; if (product !== 32'h0) $display("FAIL reset_product: got %h expected 0", product); else pass_cnt++;
        total_cnt++; if (status !== 16'h0) $display("FAIL reset_status: got %h expected 0", status); else pass_cnt++;
        RST = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        A = 16'd3; B = 16'd5; start = 1'b1;
        tick();
        start = 1'b0; A = 16'hFFFF; B = 16'hFFFF;
        for (int i = 0; i <= WIDTH + 1; i++) begin
            total_cnt++;
            if (busy !== (i <= WIDTH)) $display("FAIL lat_busy[%0d]: got %b expected %b", i, busy, (i <= WIDTH));
            else pass_cnt++;
            total_cnt++;
            if (done !== (i == WIDTH)) $display("FAIL lat_done[%0d]: got %b expected %b", i, done, (i == WIDTH));
            else pass_cnt++;
            if (i < WIDTH) begin
                total_cnt++;
                if (product !== 32'h0) $display("FAIL lat_hold[%0d]: got %h expected 0", i, product);
                else pass_cnt++;
            end
            if (i < WIDTH + 1) tick();
        end
        total_cnt++; if (product !== 32'h0000000F) $display("FAIL lat_product: got %h expected 0000000f", product); else pass_cnt++;
        total_cnt++; if (status !== 16'h0000) $display("FAIL lat_status: got %h expected 0000", status); else pass_cnt++;
    endtask

    task automatic test_vectors();
        logic [15:0] va [6] = '{16'hFFFF, 16'h8000, 16'h0000, 16'h0001, 16'hFFFF, 16'h0002};
        logic [15:0] vb [6] = '{16'hFFFF, 16'h0002, 16'h1234, 16'h1234, 16'h0000, 16'h8000};
        int lat, pulses;
        logic [31:0] ep;
        for (int k = 0; k < 6; k++) begin
            run_op(va[k], vb[k], lat, pulses);
            ep = model_product(va[k], vb[k]);
            total_cnt++; if (lat !== WIDTH) $display("FAIL vec%0d_latency: got %0d expected %0d", k, lat, WIDTH); else pass_cnt++;
            total_cnt++; if (pulses !== 1) $display("FAIL vec%0d_pulses: got %0d expected 1", k, pulses); else pass_cnt++;
            total_cnt++; if (product !== ep) $display("FAIL vec%0d_product: got %h expected %h", k, product, ep); else pass_cnt++;
            total_cnt++; if (status !== model_status(ep)) $display("FAIL vec%0d_status: got %h expected %h", k, status, model_status(ep)); else pass_cnt++;
        end
    endtask

    task automatic test_busy_ignore();
        int lat, pulses;
        A = 16'd7; B = 16'd9; start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (int i = 1; i <= WIDTH + 1; i++) begin
            tick();
            if (done === 1'b1) pulses++;
            if (i == 4) begin start = 1'b1; A = 16'd2; B = 16'd2; end
            if (i == 5) start = 1'b0;
            if (i == WIDTH) begin
                total_cnt++; if (product !== 32'd63) $display("FAIL ign_product: got %h expected %h", product, 32'd63); else pass_cnt++;
                start = 1'b1;
            end
            if (i == WIDTH + 1) begin
                total_cnt++; if (busy !== 1'b0) $display("FAIL ign_idle_after_done: got %b expected 0", busy); else pass_cnt++;
            end
        end
        total_cnt++; if (pulses !== 1) $display("FAIL ign_pulses: got %0d expected 1", pulses); else pass_cnt++;
        tick();
        start = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL ign_accept_edge18: got %b expected 1", busy); else pass_cnt++;
        total_cnt++; if (product !== 32'd63) $display("FAIL ign_hold: got %h expected %h", product, 32'd63); else pass_cnt++;
        wait_done(lat, pulses);
        total_cnt++; if (lat !== WIDTH) $display("FAIL ign2_latency: got %0d expected %0d", lat, WIDTH); else pass_cnt++;
        total_cnt++; if (product !== 32'd4) $display("FAIL ign2_product: got %h expected 4", product); else pass_cnt++;
    endtask

    task automatic test_reset_midrun();
        int lat, pulses;
        A = 16'd100; B = 16'd100; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL mid_done: got %b expected 0", done); else pass_cnt++;
        total_cnt++; if (product !== 32'h0) $display("FAIL mid_product: got %h expected 0", product); else pass_cnt++;
        total_cnt++; if (status !== 16'h0) $display("FAIL mid_status: got %h expected 0", status); else pass_cnt++;
        wait_done(lat, pulses);
        total_cnt++; if (pulses !== 0) $display("FAIL mid_no_pulse: got %0d expected 0", pulses); else pass_cnt++;
        run_op(16'd100, 16'd100, lat, pulses);
        total_cnt++; if (product !== 32'd10000) $display("FAIL mid_rerun_product: got %h expected %h", product, 32'd10000); else pass_cnt++;
        total_cnt++; if (status !== 16'h0000) $display("FAIL mid_rerun_status: got %h expected 0000", status); else pass_cnt++;
    endtask

    task automatic test_reset_start_overlap();
        int lat, pulses;
        RST = 1'b1; start = 1'b1; A = 16'h00AB; B = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if (busy !== 1'b0) $display("FAIL ovl_busy[%0d]: got %b expected 0", i, busy); else pass_cnt++;
        end
        RST = 1'b0;
        tick();
        start = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL ovl_accept: got %b expected 1", busy); else pass_cnt++;
        wait_done(lat, pulses);
        total_cnt++; if (lat !== WIDTH) $display("FAIL ovl_latency: got %0d expected %0d", lat, WIDTH); else pass_cnt++;
        total_cnt++; if (product !== 32'h0000AB00) $display("FAIL ovl_product: got %h expected 0000ab00", product); else pass_cnt++;
    endtask

    task automatic test_random();
        int lat, pulses;
        logic [15:0] a, b;
        logic [31:0] ep;
        for (int k = 0; k < 24; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (k % 8 == 3) a = 16'hFFFF - 16'($urandom_range(0, 3));
            if (k % 8 == 5) b = 16'($urandom_range(0, 2));
            run_op(a, b, lat, pulses);
            ep = model_product(a, b);
            total_cnt++; if (pulses !== 1 || lat !== WIDTH) $display("FAIL rnd%0d_timing: got lat %0d pulses %0d expected lat %0d pulses 1", k, lat, pulses, WIDTH); else pass_cnt++;
            total_cnt++; if (product !== ep) $display("FAIL rnd%0d_product: %h*%h got %h expected %h", k, a, b, product, ep); else pass_cnt++;
            total_cnt++; if (status !== model_status(ep)) $display("FAIL rnd%0d_status: got %h expected %h", k, status, model_status(ep)); else pass_cnt++;
        end
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; A = '0; B = '0;
        test_reset();
        test_latency();
        test_vectors();
        test_busy_ignore();
        test_reset_midrun();
        test_reset_start_overlap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
